// File: rtl/uart_th_decode.sv
// uart_th_decode: parses the 12-byte ASCII frame "TT.T",0xA1,0xE6," ","HH.H","%"
// back into temperature and humidity in tenths of a unit.
// Optional build macro: UART_TH_DECODE_LITERAL_CHECK_EN. When it is defined, the
// literal bytes are checked exactly. When it is not defined, literal positions
// accept any byte.
module uart_th_decode #(
   parameter logic [25:0] TIMEOUT_CYC = 26'd5_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_byte,
   input  logic       rx_byte_vld,
   output logic [9:0] temp_val,
   output logic [9:0] humi_val,
   output logic       val_vld,
   output logic       frame_err,
   output logic       rx_busy
);

   typedef enum logic {IDLE, RECV} state_t;

   state_t      state, state_nxt;
   logic [3:0]  pos, pos_nxt;
   logic [9:0]  t_acc, t_acc_nxt, h_acc, h_acc_nxt;
   logic [9:0]  temp_nxt, humi_nxt;
   logic        val_nxt, err_nxt;
   logic [25:0] idle_cnt, idle_cnt_nxt;

   logic        is_digit;
   logic [3:0]  digit;
   logic        digit_pos;
   logic        byte_ok;
   logic [9:0]  t_mac, h_mac;

   // Classify the incoming byte and precompute the x10 + digit accumulations
   always_comb begin
      is_digit  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
      digit     = rx_byte[3:0];
      digit_pos = pos inside {4'd0, 4'd1, 4'd3, 4'd7, 4'd8, 4'd10};
      t_mac     = (t_acc << 3) + (t_acc << 1) + {6'd0, digit};
      h_mac     = (h_acc << 3) + (h_acc << 1) + {6'd0, digit};
`ifdef UART_TH_DECODE_LITERAL_CHECK_EN
      case (pos)
         4'd2, 4'd9: byte_ok = (rx_byte == 8'h2E);
         4'd4:       byte_ok = (rx_byte == 8'hA1);
         4'd5:       byte_ok = (rx_byte == 8'hE6);
         4'd6:       byte_ok = (rx_byte == 8'h20);
         4'd11:      byte_ok = (rx_byte == 8'h25);
         default:    byte_ok = is_digit;
      endcase
`else
      byte_ok = digit_pos ? is_digit : 1'b1;
`endif
   end

   // Next-state logic: byte acceptance, resync on mismatch, and the inter-byte timeout
   always_comb begin
      pos_nxt      = pos;
      t_acc_nxt    = t_acc;
      h_acc_nxt    = h_acc;
      temp_nxt     = temp_val;
      humi_nxt     = humi_val;
      val_nxt      = 1'b0;
      err_nxt      = 1'b0;
      idle_cnt_nxt = idle_cnt;
      if (rx_byte_vld) begin
         idle_cnt_nxt = 26'd0;
         if (byte_ok) begin
            case (pos)
               4'd0:        t_acc_nxt = {6'd0, digit};
               4'd1, 4'd3:  t_acc_nxt = t_mac;
               4'd7:        h_acc_nxt = {6'd0, digit};
               4'd8, 4'd10: h_acc_nxt = h_mac;
               default:     ;
            endcase
            if (pos == 4'd11) begin
               temp_nxt = t_acc;
               humi_nxt = h_acc;
               val_nxt  = 1'b1;
               pos_nxt  = 4'd0;
            end else begin
               pos_nxt = pos + 4'd1;
            end
         end else begin
            err_nxt = 1'b1;
            if (is_digit && (pos != 4'd0)) begin
               t_acc_nxt = {6'd0, digit};
               pos_nxt   = 4'd1;
            end else begin
               pos_nxt = 4'd0;
            end
         end
      end else if (state == IDLE) begin
         idle_cnt_nxt = 26'd0;
      end else if (idle_cnt == (TIMEOUT_CYC - 26'd1)) begin
         err_nxt      = 1'b1;
         pos_nxt      = 4'd0;
         idle_cnt_nxt = 26'd0;
      end else begin
         idle_cnt_nxt = idle_cnt + 26'd1;
      end
      state_nxt = (pos_nxt == 4'd0) ? IDLE : RECV;
   end

   // Register all state and outputs; reset clears everything, including mid-frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pos       <= 4'd0;
         t_acc     <= 10'd0;
         h_acc     <= 10'd0;
         idle_cnt  <= 26'd0;
         temp_val  <= 10'd0;
         humi_val  <= 10'd0;
         val_vld   <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pos       <= pos_nxt;
         t_acc     <= t_acc_nxt;
         h_acc     <= h_acc_nxt;
         idle_cnt  <= idle_cnt_nxt;
         temp_val  <= temp_nxt;
         humi_val  <= humi_nxt;
         val_vld   <= val_nxt;
         frame_err <= err_nxt;
         rx_busy   <= (pos_nxt != 4'd0);
      end
   end

endmodule

// File: tb/tb_uart_th_decode.sv
// tb_uart_th_decode: scoreboard bench for uart_th_decode with a frame-level reference model.
module tb_uart_th_decode;

   localparam int T = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_byte_vld = 1'b0;
   logic [9:0] temp_val, humi_val;
   logic       val_vld, frame_err, rx_busy;

   typedef struct {
      bit is_err;
      int temp;
      int humi;
      bit busy;
   } ev_t;

   ev_t          exp_q[$];
   byte unsigned frame_buf[$];
   int           n_pass = 0;
   int           n_total = 0;
   int           held_t = 0;
   int           held_h = 0;

   uart_th_decode #(.TIMEOUT_CYC(26'(T))) dut (
      .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld),
      .temp_val(temp_val), .humi_val(humi_val), .val_vld(val_vld),
      .frame_err(frame_err), .rx_busy(rx_busy)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic bit isDigit(byte unsigned b);
      return (b >= 8'h30) && (b <= 8'h39);
   endfunction

   // Would byte b be accepted as character number p of a frame?
   function automatic bit byteOk(int p, byte unsigned b);
      byte unsigned lit[12] = '{8'h00, 8'h00, 8'h2E, 8'h00, 8'hA1, 8'hE6,
                                8'h20, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h25};
      if (p inside {0, 1, 3, 7, 8, 10}) return isDigit(b);
`ifdef UART_TH_DECODE_LITERAL_CHECK_EN
      return b == lit[p];
`else
      return 1'b1;
`endif
   endfunction

   function automatic int dv(byte unsigned b);
      return int'(b) - 48;
   endfunction

   // Reference model: keep the accepted prefix of the frame as a list of characters
   function automatic void modelByte(byte unsigned b);
      ev_t e;
      int  p = frame_buf.size();
      if (byteOk(p, b)) begin
         frame_buf.push_back(b);
         if (frame_buf.size() == 12) begin
            e.is_err = 1'b0;
            e.temp   = dv(frame_buf[0]) * 100 + dv(frame_buf[1]) * 10 + dv(frame_buf[3]);
            e.humi   = dv(frame_buf[7]) * 100 + dv(frame_buf[8]) * 10 + dv(frame_buf[10]);
            e.busy   = 1'b0;
            exp_q.push_back(e);
            frame_buf.delete();
         end
      end else begin
         frame_buf.delete();
         if (isDigit(b) && p != 0) frame_buf.push_back(b);
         e.is_err = 1'b1;
         e.temp   = 0;
         e.humi   = 0;
         e.busy   = (frame_buf.size() != 0);
         exp_q.push_back(e);
      end
   endfunction

   function automatic void modelGap(int gap);
      ev_t e;
      if (gap >= T && frame_buf.size() != 0) begin
         e.is_err = 1'b1;
         e.temp   = 0;
         e.humi   = 0;
         e.busy   = 1'b0;
         exp_q.push_back(e);
         frame_buf.delete();
      end
   endfunction

   // Drive one byte strobe, then hold the line idle for gap cycles
   task automatic applyStimulus(input byte unsigned b, input int gap);
      modelByte(b);
      modelGap(gap);
      rx_byte     = b;
      rx_byte_vld = 1'b1;
      @(posedge clk); #1;
      rx_byte_vld = 1'b0;
      rx_byte     = 8'(($urandom));
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic buildFrame(input int t, input int h, output byte unsigned f[12]);
      f[0]  = 8'(48 + t / 100);
      f[1]  = 8'(48 + (t / 10) % 10);
      f[2]  = 8'h2E;
      f[3]  = 8'(48 + t % 10);
      f[4]  = 8'hA1;
      f[5]  = 8'hE6;
      f[6]  = 8'h20;
      f[7]  = 8'(48 + h / 100);
      f[8]  = 8'(48 + (h / 10) % 10);
      f[9]  = 8'h2E;
      f[10] = 8'(48 + h % 10);
      f[11] = 8'h25;
   endtask

   task automatic sendFrame(input int t, input int h, input int nbytes);
      byte unsigned f[12];
      buildFrame(t, h, f);
      for (int i = 0; i < nbytes; i++) applyStimulus(f[i], 0);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      frame_buf.delete();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_temp_val", int'(temp_val), 0);
      checkOutput("reset_humi_val", int'(humi_val), 0);
      checkOutput("reset_val_vld", int'(val_vld), 0);
      checkOutput("reset_frame_err", int'(frame_err), 0);
      checkOutput("reset_rx_busy", int'(rx_busy), 0);
      checkOutput("reset_pending_events", exp_q.size(), 0);
      rst_n = 1'b1;
   endtask

   // Monitor: pop the scoreboard on every output pulse and compare
   always @(negedge clk) begin
      ev_t e;
      if (!rst_n) begin
         held_t = 0;
         held_h = 0;
      end else if (val_vld || frame_err) begin
         checkOutput("pulse_exclusive", int'(val_vld && frame_err), 0);
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_pulse_err", int'(frame_err), 0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("pulse_is_err", int'(frame_err), int'(e.is_err));
            if (!e.is_err) begin
               held_t = e.temp;
               held_h = e.humi;
            end
            checkOutput("temp_val", int'(temp_val), held_t);
            checkOutput("humi_val", int'(humi_val), held_h);
            checkOutput("rx_busy", int'(rx_busy), int'(e.busy));
         end
      end
   end

   // Directed scenarios followed by randomized frames with corruption and gaps
   initial begin
      byte unsigned f[12];
      int           t, h, gap, bad_pos;
      doReset();
      sendFrame(253, 601, 12);
      repeat (3) @(posedge clk); #1;
      sendFrame(0, 0, 12);
      sendFrame(999, 999, 12);
      applyStimulus(8'h32, 0);
      applyStimulus(8'h58, 0);
      sendFrame(123, 456, 12);
      sendFrame(253, 0, 4);
      applyStimulus(8'h37, T + 5);
      sendFrame(250, 0, 2);
      applyStimulus(8'h2E, T);
      sendFrame(250, 0, 1);
      applyStimulus(8'h35, T - 1);
      applyStimulus(8'h2E, 0);
      buildFrame(250, 887, f);
      for (int i = 3; i < 12; i++) applyStimulus(f[i], 0);
      sendFrame(318, 742, 8);
      doReset();
      sendFrame(318, 742, 12);
      for (int n = 0; n < 60; n++) begin
         t = $urandom_range(0, 999);
         h = $urandom_range(0, 999);
         buildFrame(t, h, f);
         bad_pos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 11) : -1;
         if (bad_pos >= 0)
            f[bad_pos] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(48, 57));
         for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 29))
               0:       gap = T - 1;
               1:       gap = T + $urandom_range(0, 3);
               default: gap = $urandom_range(0, 2);
            endcase
            applyStimulus(f[i], gap);
         end
      end
      modelGap(T + 10);
      repeat (T + 10) @(posedge clk);
      #1;
      checkOutput("pending_events_at_end", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
